// File: rtl/audio_rom_pkg.sv
// Shared constants for the audio lookup ROMs: the 32-note frequency table,
// the period rounding helper and the fixed-point quarter-wave sine generator.
package audio_rom_pkg;

    localparam int FREQ_BASE      = 270;
    localparam int PERIOD_NUM     = 65536;
    localparam int PHASE_POINTS   = 1024;
    localparam int QUARTER_POINTS = PHASE_POINTS / 4;
    localparam int NOTE_COUNT     = 32;

    typedef logic [10:0] freq_t;
    typedef logic [15:0] period_t;

    typedef struct packed {
        freq_t   freq;
        period_t period;
    } note_t;

    // round(FREQ_BASE * 2^((id-12)/12)), one semitone per entry.
    localparam freq_t FREQ_TABLE [NOTE_COUNT] = '{
        11'(FREQ_BASE / 2), 11'd143, 11'd152, 11'd161,
        11'd170,            11'd180, 11'd191, 11'd202,
        11'd214,            11'd227, 11'd241, 11'd255,
        11'(FREQ_BASE),     11'd286, 11'd303, 11'd321,
        11'd340,            11'd360, 11'd382, 11'd405,
        11'd429,            11'd454, 11'd481, 11'd510,
        11'(FREQ_BASE * 2), 11'd572, 11'd606, 11'd642,
        11'd680,            11'd721, 11'd764, 11'd809
    };

    // round-half-up of PERIOD_NUM / f, evaluated only at elaboration.
    function automatic period_t period_of(input int f);
        return period_t'((2 * PERIOD_NUM + f) / (2 * f));
    endfunction

    // pi in unsigned Q60 fixed point.
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    // round(A * sin(2*pi*k/1024)) with A = 2^(bits-1)-1, using a Q60 Taylor
    // series so the result does not depend on any tool's real-number support.
    function automatic logic [9:0] quarter_mag(input int bits, input int k);
        logic [127:0] theta;
        logic [127:0] theta2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] amp;
        theta  = (PI_Q60 * 128'(k)) >> 9;
        theta2 = (theta * theta) >> 60;
        term   = theta;
        sum    = theta;
        for (int n = 1; n <= 14; n++) begin
            term = ((term * theta2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if ((n % 2) == 1) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        amp = 128'((1 << (bits - 1)) - 1);
        return 10'((amp * sum + (128'(1) << 59)) >> 60);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table, entries 0..255, built from BITS at
// elaboration; the peak entry (k = 256) is supplied by the caller.
module sine_quarter_rom
    import audio_rom_pkg::*;
#(
    parameter int BITS = 6
) (
    input  logic [7:0]      k,
    output logic [BITS-2:0] magnitude
);

    logic [BITS-2:0] table_w [QUARTER_POINTS];

    for (genvar g = 0; g < QUARTER_POINTS; g++) begin : g_entry
        localparam logic [9:0] MAG = quarter_mag(BITS, g);
        assign table_w[g] = MAG[BITS-2:0];
    end

    assign magnitude = table_w[k];

endmodule

// File: rtl/audio_rom.sv
// Registered audio lookup: sine level by phase index, plus note frequency
// and period constants by freq_id. All outputs have one cycle of latency.
module audio_rom
    import audio_rom_pkg::*;
#(
    parameter int BITS = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [9:0]      index,
    input  logic [4:0]      freq_id,
    output logic [BITS-1:0] level,
    output logic [10:0]     freq,
    output logic [15:0]     period
);

    // A = 2^(BITS-1)-1 is exactly the all-ones value of the magnitude width.
    localparam logic [BITS-2:0] AMP = '1;

    logic [1:0]      quad_w;
    logic [7:0]      k_w;
    logic [7:0]      rom_addr_w;
    logic [BITS-2:0] rom_mag_w;
    logic [BITS-2:0] mag_w;
    logic            peak_w;

    logic [BITS-1:0] level_d, level_q;
    note_t           note_d;
    freq_t           freq_q;
    period_t         period_q;

    note_t note_rom_w [NOTE_COUNT];

    for (genvar g = 0; g < NOTE_COUNT; g++) begin : g_note
        localparam period_t PER = period_of(int'(FREQ_TABLE[g]));
        assign note_rom_w[g] = '{freq: FREQ_TABLE[g], period: PER};
    end

    sine_quarter_rom #(
        .BITS(BITS)
    ) u_quarter (
        .k        (rom_addr_w),
        .magnitude(rom_mag_w)
    );

    // Odd quadrants read the table backwards: M(256-k); k = 0 there is the peak.
    always_comb begin
        quad_w     = index[9:8];
        k_w        = index[7:0];
        rom_addr_w = quad_w[0] ? (~k_w + 8'd1) : k_w;
        peak_w     = quad_w[0] && (k_w == 8'd0);
        mag_w      = peak_w ? AMP : rom_mag_w;
        level_d    = quad_w[1] ? ({1'b0, AMP} - {1'b0, mag_w})
                               : ({1'b0, AMP} + {1'b0, mag_w});
        note_d     = note_rom_w[freq_id];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q  <= '0;
            freq_q   <= '0;
            period_q <= '0;
        end else begin
            level_q  <= level_d;
            freq_q   <= note_d.freq;
            period_q <= note_d.period;
        end
    end

    assign level  = level_q;
    assign freq   = freq_q;
    assign period = period_q;

endmodule

// File: tb/tb_audio_rom.sv
// Bench for audio_rom: BITS=6 and BITS=8 instances share inputs; a driver
// queues expected outputs and a monitor compares them one cycle later.
module tb_audio_rom;

    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic        chk_l6;
        logic [5:0]  l6;
        logic        chk_l8;
        logic [7:0]  l8;
        logic [10:0] f;
        logic [15:0] p;
    } exp_t;

    // Hand-computed note constants (round-half-up).
    localparam int FREQ_T [32] = '{
        135, 143, 152, 161, 170, 180, 191, 202, 214, 227, 241, 255,
        270, 286, 303, 321, 340, 360, 382, 405, 429, 454, 481, 510,
        540, 572, 606, 642, 680, 721, 764, 809};
    localparam int PERIOD_T [32] = '{
        485, 458, 431, 407, 386, 364, 343, 324, 306, 289, 272, 257,
        243, 229, 216, 204, 193, 182, 172, 162, 153, 144, 136, 129,
        121, 115, 108, 102, 96, 91, 86, 81};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  index = '0;
    logic [4:0]  freq_id = '0;
    logic [5:0]  level6;
    logic [7:0]  level8;
    logic [10:0] freq6, freq8;
    logic [15:0] period6, period8;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;

    audio_rom #(.BITS(6)) dut6 (
        .clock(clock), .reset(reset), .index(index), .freq_id(freq_id),
        .level(level6), .freq(freq6), .period(period6));

    audio_rom #(.BITS(8)) dut8 (
        .clock(clock), .reset(reset), .index(index), .freq_id(freq_id),
        .level(level8), .freq(freq8), .period(period8));

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int ref_level(input int a, input int idx);
        real x;
        x = a * (1.0 + $sin(2.0 * PI * idx / 1024.0));
        return int'($floor(x + 0.5));
    endfunction

    function automatic exp_t mk(input int l6, input bit c8, input int l8, input int fid);
        exp_t e;
        e.chk_l6 = 1'b1;
        e.l6     = 6'(l6);
        e.chk_l8 = c8;
        e.l8     = 8'(l8);
        e.f      = 11'(FREQ_T[fid]);
        e.p      = 16'(PERIOD_T[fid]);
        return e;
    endfunction

    function automatic exp_t mk_model(input int idx, input int fid);
        return mk(ref_level(31, idx), 1'b1, ref_level(127, idx), fid);
    endfunction

    // Apply one input vector on the falling edge; optionally release reset with it.
    task automatic drive(input int idx, input int fid, input exp_t e, input bit release_rst);
        @(negedge clock);
        if (release_rst) reset = 1'b0;
        index   = 10'(idx);
        freq_id = 5'(fid);
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level6"}, level6, 0);
        check({tag, "_freq6"}, freq6, 0);
        check({tag, "_period6"}, period6, 0);
        check({tag, "_level8"}, level8, 0);
        check({tag, "_freq8"}, freq8, 0);
        check({tag, "_period8"}, period8, 0);
    endtask

    // Monitor: one expected entry applies to each rising edge after it was queued.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (!reset && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_l6) begin
                    check("level6", level6, mon_e.l6);
                    check("level6_le_62", int'(level6 <= 6'd62), 1);
                end
                if (mon_e.chk_l8) check("level8", level8, mon_e.l8);
                check("freq6", freq6, mon_e.f);
                check("period6", period6, mon_e.p);
                check("freq8", freq8, mon_e.f);
                check("period8", period8, mon_e.p);
                check("freq_period_1pct",
                      int'((int'(freq6) * int'(period6) >= 64880) &&
                           (int'(freq6) * int'(period6) <= 66192)), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held from time 0: outputs zero before and across clock edges.
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge clock);
        #2;
        check_zero("rst_held");

        // First edge after release shows the lookup for the current inputs.
        drive(0, 12, mk(31, 1'b1, 127, 12), 1'b1);
        drive(0, 0, mk(31, 1'b1, 127, 0), 1'b0);
        drive(0, 31, mk(31, 1'b1, 127, 31), 1'b0);

        drive(128, 12, mk(53, 1'b1, 217, 12), 1'b0);
        drive(256, 12, mk(62, 1'b1, 254, 12), 1'b0);
        drive(512, 0, mk(31, 1'b1, 127, 0), 1'b0);
        drive(768, 31, mk(0, 1'b1, 0, 31), 1'b0);
        drive(255, 24, mk(62, 1'b0, 0, 24), 1'b0);
        drive(257, 5, mk(62, 1'b0, 0, 5), 1'b0);
        drive(767, 19, mk(0, 1'b0, 0, 19), 1'b0);
        drive(1023, 23, mk(31, 1'b0, 0, 23), 1'b0);

        for (int i = 0; i < 1024; i++) begin
            if (i == 600) begin
                @(posedge clock);
                #3;
                check("queue_empty_before_reset", exp_q.size(), 0);
                reset = 1'b1;
                #1;
                check_zero("rst_mid");
                @(posedge clock);
                #2;
                check_zero("rst_mid_held");
                drive(i, i % 32, mk_model(i, i % 32), 1'b1);
            end else begin
                drive(i, i % 32, mk_model(i, i % 32), 1'b0);
            end
        end

        @(posedge clock);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/audio_rom.md
AUDIO_ROM -- requirements
Module: audio_rom

Interface
REQ-001 SHALL have parameter BITS, default 6, giving the width of the level output in bits (legal range 4..10).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port index, input, 10 bits: phase within one waveform period (0..1023; 512 = half period).
REQ-005 SHALL have port freq_id, input, 5 bits: note selector (0..31), one semitone per step.
REQ-006 SHALL have port level, output, BITS bits: unsigned sine sample for index.
REQ-007 SHALL have port freq, output, 11 bits: phase-increment constant for freq_id.
REQ-008 SHALL have port period, output, 16 bits: period constant for freq_id.

Function
REQ-009 SHALL register all three outputs; each output reflects the inputs sampled at the previous rising clock edge (latency exactly 1 cycle, no handshake, new lookup every cycle).
REQ-010 SHALL compute the frequency table as freq(id) = round(270 * 2^((id-12)/12)): id 0 -> 135, id 12 -> 270, id 24 -> 540, id 31 -> 809.
REQ-011 SHALL compute the period table as period(id) = round(65536 / freq(id)): id 0 -> 485, id 12 -> 243, id 24 -> 121, id 31 -> 81.
REQ-012 SHALL use round-half-up for every table constant.
REQ-013 SHALL treat all 32 freq_id codes as valid; there is no out-of-range case.
REQ-014 SHALL compute level = round(A * (1 + sin(2*pi*index/1024))), with A = 2^(BITS-1) - 1.
REQ-015 For BITS=6 (A=31), level SHALL be: index 0 -> 31, 128 -> 53, 256 -> 62, 512 -> 31, 768 -> 0.
REQ-016 SHALL keep level within 0..2A; no overflow is permitted at any index.
REQ-017 SHALL derive level from a 256-entry quarter-wave magnitude table M(k) = round(A * sin(2*pi*k/1024)), k = 0..255, plus a separately handled peak value A for k = 256.
REQ-018 Quarter-wave mirroring, with q = index[9:8] and k = index[7:0]:
- q=0: A + M(k)
- q=1: A + M(256-k), where k=0 uses the peak A
- q=2: A - M(k)
- q=3: A - M(256-k), where k=0 uses the peak A
REQ-019 SHALL make the mirrored result bit-exact with REQ-014 at every one of the 1024 indices.
REQ-020 SHALL update index and freq_id lookups independently; a freq_id change does not disturb the level pipeline.
REQ-021 SHALL have no internal state other than the output registers.

Reset
REQ-022 While reset is high, level, freq and period SHALL be 0, asynchronously and regardless of clock.
REQ-023 On the first rising edge after reset deasserts, outputs SHALL show the lookups for the current inputs.
REQ-024 Reset asserted mid-stream SHALL zero the outputs immediately, with no partial update.

Structure
REQ-025 A shared package SHALL hold the 32-entry freq and period constant tables and the base constants (270, 65536, 1024-point phase).
REQ-026 One sub-module, sine_quarter_rom (parameter BITS; input k 8 bits; output magnitude), SHALL hold the quarter-wave table generated from BITS at elaboration.
REQ-027 The quarter-wave mirroring and output registers SHALL live in audio_rom.

Verification
REQ-028 freq_id=12 -> one cycle later freq=270 and period=243; freq_id=0 -> 135/485; freq_id=31 -> 809/81.
REQ-029 BITS=6, index sweep 0,128,256,512,768 -> level 31,53,62,31,0, each one cycle after the index is applied.
REQ-030 Full sweep of index 0..1023 -> level matches the REQ-014 reference model at every point and never exceeds 62.
REQ-031 Reset pulse mid-sweep between clock edges -> all outputs 0 immediately; correct lookups resume on the first edge after release.
REQ-032 For every freq_id, freq*period SHALL lie within 65536 +/- 1% (e.g. 270*243 = 65610).
REQ-033 With BITS=8 (A=127), index 256 -> level 254 and index 768 -> level 0.
